// File: rtl/tcore_param.sv
// Shared core types: access sizes, LSU states and exception codes.
// Also holds the byte-enable, lane-replication and misalignment helpers.
package tcore_param;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    BYTE = 2'b01,
    HALF = 2'b10,
    WORD = 2'b11
  } rw_size_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } lsu_state_e;

  typedef enum logic [3:0] {
    NO_EXCEPTION     = 4'd0,
    ILLEGAL_INSTR    = 4'd1,
    LOAD_MISALIGNED  = 4'd2,
    STORE_MISALIGNED = 4'd3
  } exc_type_e;

  function automatic logic misaligned(
    input rw_size_e   sz,
    input logic [1:0] off
  );
    unique case (sz)
      HALF:    return off[0];
      WORD:    return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(
    input rw_size_e   sz,
    input logic [1:0] off
  );
    unique case (sz)
      BYTE:    return 4'b0001 << off;
      HALF:    return 4'b0011 << off;
      WORD:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(
    input rw_size_e    sz,
    input logic [31:0] wd
  );
    unique case (sz)
      BYTE:    return {4{wd[7:0]}};
      HALF:    return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/memory_access_unit_if.sv
// Data-memory bus between the LSU (master) and memory (slave).
// Request fields are held stable by the master until dmem_ready_i.
interface memory_access_unit_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ready_i;
  logic [31:0] dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o,
    output dmem_be_o, dmem_wdata_o,
    input  dmem_ready_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o,
    input  dmem_be_o, dmem_wdata_o,
    output dmem_ready_i, dmem_rdata_i
  );
endinterface

// File: rtl/load_aligner.sv
// Picks the addressed lane out of a read word and zero/sign-extends it.
// Ports: word, offset, size, sign in; data (32-bit) out.
module load_aligner
  import tcore_param::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  rw_size_e    size,
  input  logic        sign,
  output logic [31:0] data
);
  logic [31:0] sh;

  assign sh = word >> {offset, 3'b000};

  always_comb begin
    data = '0;
    unique case (1'b1)
      size == BYTE:
        data = {{24{sign & sh[7]}}, sh[7:0]};
      size == HALF:
        data = {{16{sign & sh[15]}}, sh[15:0]};
      size == WORD:
        data = sh;
      default:
        data = '0;
    endcase
  end
endmodule

// File: rtl/memory_access_unit.sv
// Memory stage LSU: issues one bus access per load/store, stalls until ack.
// Ports: clk_i/rst_ni, request in, dmem master bus, stall/done/rdata/exc out.
module memory_access_unit
  import tcore_param::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  input  logic                 wr_en_i,
  input  logic [1:0]           rw_size_i,
  input  logic                 ld_op_sign_i,
  input  logic [31:0]          addr_i,
  input  logic [31:0]          wdata_i,
  input  logic                 flush_i,
  memory_access_unit_if.master dmem,
  output logic                 stall_o,
  output logic                 done_o,
  output logic [31:0]          rdata_o,
  output exc_type_e            exc_o
);
  lsu_state_e  state_q, state_d;
  logic        req_q, we_q, sign_q, drop_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic [1:0]  off_q;
  rw_size_e    size_q;

  rw_size_e    size;
  logic        try_acc, mis, go, fin, drop;
  logic [31:0] ld_data;

  assign size = rw_size_e'(rw_size_i);

  // a flushed instruction never starts nor traps
  assign try_acc = rst_ni && state_q == IDLE && valid_i
                 && !flush_i && size != NONE;
  assign mis  = try_acc && misaligned(size, addr_i[1:0]);
  assign go   = try_acc && !mis;
  assign fin  = state_q == WAIT && dmem.dmem_ready_i;
  // a flush arriving on the completion cycle also drops it
  assign drop = drop_q || flush_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (go) state_d = WAIT;
      WAIT: if (fin) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      off_q   <= '0;
      size_q  <= NONE;
      sign_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= state_q == WAIT && !fin && drop;
      if (go) begin
        req_q   <= 1'b1;
        we_q    <= wr_en_i;
        addr_q  <= {addr_i[31:2], 2'b00};
        be_q    <= byte_en(size, addr_i[1:0]);
        wdata_q <= lane_data(size, wdata_i);
        off_q   <= addr_i[1:0];
        size_q  <= size;
        sign_q  <= ld_op_sign_i;
      end else if (fin) begin
        req_q   <= 1'b0;
        we_q    <= 1'b0;
        addr_q  <= '0;
        be_q    <= '0;
        wdata_q <= '0;
      end
    end
  end

  load_aligner u_aligner (
    .word   (dmem.dmem_rdata_i),
    .offset (off_q),
    .size   (size_q),
    .sign   (sign_q),
    .data   (ld_data)
  );

  assign dmem.dmem_req_o   = req_q;
  assign dmem.dmem_we_o    = we_q;
  assign dmem.dmem_addr_o  = addr_q;
  assign dmem.dmem_be_o    = be_q;
  assign dmem.dmem_wdata_o = wdata_q;

  assign stall_o = go || (state_q == WAIT && !dmem.dmem_ready_i);
  assign done_o  = fin && !drop;
  assign rdata_o = (done_o && !we_q) ? ld_data : '0;

  always_comb begin
    exc_o = NO_EXCEPTION;
    if (mis)
      exc_o = wr_en_i ? STORE_MISALIGNED : LOAD_MISALIGNED;
  end
endmodule

// File: doc/memory_access_unit.md
MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk_i  in  1  core clock; rst_ni  in  1  async active-low reset.
REQ-002 The request ports SHALL be:
- valid_i  in  1  memory instruction present in stage.
- wr_en_i  in  1  1=store, 0=load.
- rw_size_i  in  2  00 none, 01 byte, 10 half, 11 word.
- ld_op_sign_i  in  1  sign-extend load data.
- addr_i  in  32  byte address.
- wdata_i  in  32  store data, LSB-justified.
- flush_i  in  1  discard the in-flight result.
REQ-003 The bus ports SHALL be:
- dmem_req_o  out  1  bus request.
- dmem_we_o  out  1  write.
- dmem_addr_o  out  32  word address, bits [1:0]=0.
- dmem_be_o  out  4  byte enables.
- dmem_wdata_o  out  32  lane-shifted store data.
- dmem_ready_i  in  1  response/ack.
- dmem_rdata_i  in  32  read word.
REQ-004 The pipeline-side output ports SHALL be:
- stall_o  out  1  hold pipeline.
- done_o  out  1  access completes this cycle.
- rdata_o  out  32  aligned, extended load data.
- exc_o  out  exc_type_e  exception.

Function
REQ-005 An access SHALL start when valid_i=1 and rw_size_i!=00 in IDLE.
REQ-006 The FSM SHALL have exactly the states IDLE and WAIT.
REQ-007 Misalignment is half with addr[0]=1, or word with addr[1:0]!=0; a misaligned access SHALL issue no bus request, drive exc_o=LOAD_MISALIGNED/STORE_MISALIGNED combinationally for that cycle, keep stall_o=0, and stay in IDLE.
REQ-008 A legal start SHALL register req=1, we, addr {addr_i[31:2],2'b00}, be, and wdata, register offset, size and sign, assert stall_o combinationally, and go to WAIT.
REQ-009 Byte enables SHALL be: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
REQ-010 dmem_wdata_o SHALL be wdata_i replicated per lane: byte {4{b}}, half {2{h}}, word unchanged.
REQ-011 In WAIT, all dmem_* outputs SHALL hold stable until dmem_ready_i=1.
REQ-012 stall_o SHALL be 1 in WAIT while dmem_ready_i=0.
REQ-013 In WAIT with dmem_ready_i=1:
- done_o=1 and stall_o=0 combinationally;
- rdata_o = selected lane, zero- or sign-extended per the registered sign (stores: rdata_o=0);
- dmem_req_o deasserts at the next edge;
- the FSM returns to IDLE.
REQ-014 Minimum latency SHALL be 2 cycles: start cycle plus one WAIT cycle with ready=1; there is no upper bound.
REQ-015 A new access SHALL be accepted only in IDLE; valid_i in WAIT SHALL be ignored, because the pipeline is stalled.
REQ-016 flush_i in WAIT SHALL NOT abort the bus transaction; it SHALL set a drop flag so that completion gives done_o=0 and rdata_o=0.
REQ-017 The drop flag SHALL clear on return to IDLE.
REQ-018 flush_i in IDLE SHALL suppress the start.
REQ-019 dmem_ready_i in IDLE SHALL be ignored.
REQ-020 exc_o SHALL be NO_EXCEPTION whenever REQ-007 does not apply.

Reset
REQ-021 While rst_ni=0, and on any assertion including mid-WAIT, state SHALL be IDLE and all of the following SHALL be 0: dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o, stall_o, done_o, rdata_o, and the drop flag.
REQ-022 While rst_ni=0, exc_o SHALL be NO_EXCEPTION.
REQ-023 A bus response pending at reset SHALL be ignored after reset.

Structure
REQ-024 tcore_param SHALL hold:
- rw_size_e: NONE, BYTE, HALF, WORD.
- lsu_state_e: IDLE, WAIT.
- LOAD_MISALIGNED and STORE_MISALIGNED added to exc_type_e.
REQ-025 Load lane selection and extension SHALL be one combinational sub-module, load_aligner (inputs: word, offset, size, sign; output: 32-bit data).
REQ-026 The memory_access_unit SHALL have no other sub-modules.

Verification
REQ-027 Signed byte load: addr=0x1003, size=01, sign=1, rdata=0x80FF_FF_FF -> be=1000, addr_o=0x1000, rdata_o=0xFFFFFF80, done_o in cycle 2.
REQ-028 Store half: addr=0x2002, wdata=0x0000BEEF, 3 wait cycles -> be=1100, wdata_o=0xBEEFBEEF, stall_o=1 for 4 cycles, done_o on ready.
REQ-029 Misaligned accesses: word load at 0x3001 -> exc_o=LOAD_MISALIGNED, dmem_req_o=0, stall_o=0; half store at 0x3003 -> STORE_MISALIGNED.
REQ-030 Unsigned half load: addr=0x4000, rdata=0x1234_8765 -> rdata_o=0x00008765.
REQ-031 Flush: flush_i mid-WAIT on a load -> bus completes, done_o=0, rdata_o=0; next load then completes normally.
REQ-032 Reset during WAIT -> dmem_req_o=0 immediately, state IDLE, a late dmem_ready_i produces no done_o.
